flt_mant_div: RTL and testbench
===============================

// Module: flt_mant_div
// PURPOSE
//  Multi-cycle mantissa divider: consumer side of the reciprocal unit's x -> 1/x interface.
//  Sends divisor fraction B to the reciprocal unit and multiplies dividend 1.A by the returned 1/(1.B).
//  Corrects the estimate by whole ulps until the quotient is the exact truncated value.
//  Sits between the float unpack stage and the exponent/pack stage of the float divide path.
// PARAMETERS
//  FLT_WIDTH  23  fraction width (hidden 1 implicit) of A, B, rcp result and quotient
//  RCP_LAT    0   cycles from o_rcp_x stable to i_rcp_r valid (0 = combinational rcp)
//  MAX_CORR   3   max +/-1-ulp correction steps before forced exit with o_err
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  i_valid    in   1          operand strobe
//  o_ready    out  1          1 only in IDLE; accept = i_valid & o_ready
//  i_A        in   FLT_WIDTH  dividend fraction, value 1.A
//  i_B        in   FLT_WIDTH  divisor fraction, value 1.B
//  o_rcp_x    out  FLT_WIDTH  divisor fraction to reciprocal unit
//  i_rcp_r    in   FLT_WIDTH  rcp result: B!=0 -> 1/(1.B) = 1.R * 2^-1; B==0 -> 0 (means 1.0)
//  o_valid    out  1          result valid; held until i_ready
//  i_ready    in   1          downstream accept; output handshake = o_valid & i_ready
//  o_q        out  FLT_WIDTH  quotient fraction; hidden bit dropped
//  o_shift    out  1          1 when A<B: quotient = 1.q * 2^-1; exponent stage subtracts 1
//  o_err      out  1          correction limit hit; o_q is best estimate only
// BEHAVIOUR
//  Reset: state=IDLE; o_ready=1, o_valid=0, o_q=0, o_shift=0, o_err=0, o_rcp_x=0.
//    Reset in any state aborts the operation with no output.
//  Accept edge: latch A and B. Set o_rcp_x=B and hold it until MUL exits.
//    Set s = (A<B) and e = (B!=0).
//  States and transitions:
//    IDLE -> RCP on accept; goes straight to MUL when RCP_LAT=0.
//    RCP: waits RCP_LAT cycles, counted by cnt.
//    MUL: samples i_rcp_r. P = {1,A}*{1,R} (48b). Qe = P >> (23+e-s), truncated to 24b.
//    RES: N = {1,A} << (23+s). r = N - Q*{1,B}, signed, 50b. Register r.
//    CHK: if 0 <= r < {1,B}, go to DONE.
//      Else if the correction count k == MAX_CORR, go to DONE with err=1.
//      Else Q = Q-1 when r<0, or Q+1 when r >= {1,B}; k++; go to RES.
//    DONE: o_valid=1; o_q = Q[22:0]; o_shift = s; o_err = err.
//      Outputs stay stable while i_ready=0. Handshake edge -> IDLE.
//  Latency: o_valid rises 4+RCP_LAT+2k cycles after the accept edge; k = corrections used.
//  Throughput: one operation in flight. o_ready=0 from the accept edge through the output handshake edge.
//  Edge cases:
//    A==B gives s=0, Q=2^23, o_q=0.
//    B==0 forces e=0 and s=0.
//    Q increment that reaches 2^(24): clamp to 2^24-1 and set err.
//    Q decrement below 2^23: clamp to 2^23 and set err.
//  i_valid while busy is ignored; no queueing.
// STRUCTURE
//  Package flt_div_pkg holds:
//    FLT_WIDTH-derived widths: MANT_W=24, PROD_W=48, RES_W=50.
//    State encoding: IDLE, RCP, MUL, RES, CHK, DONE.
//  Sub-module flt_div_resid: combinational residual r = N - Q*D and range flags neg/ge_d.
//  Top level owns the FSM, cnt/k counters and output registers.
// TESTING
//  T1: A=0, B=0 -> o_q=0, o_shift=0, o_err=0, o_valid at +4 cycles.
//  T2: A=0x400000, B=0 (1.5/1.0) -> o_q=0x400000, o_shift=0.
//  T3: A=0, B=0x400000, exact rcp model -> o_q=0x2AAAAA, o_shift=1, o_err=0.
//  T4: rcp model biased +2 ulp, 1000 random A/B -> every o_q equals the golden truncated quotient; o_err=0.
//  T5: rcp model biased +10 ulp, MAX_CORR=3 -> o_err=1 and o_valid at +10 cycles;
//      i_ready held 0 for 5 cycles -> outputs stable and o_ready=0 throughout.
//  T6: rst pulsed during CHK -> next cycle o_valid=0 and o_ready=1; the next op completes correctly.

Source files
------------

// File: rtl/flt_div_pkg.sv
// Shared widths, FSM encoding and quotient-estimate helper for the mantissa divider.
package flt_div_pkg;

  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 32'sd1;
  localparam int PROD_W  = 32'sd2 * MANT_W;
  localparam int RES_W   = PROD_W + 32'sd2;
  localparam int FRAC_M1 = FRAC_W - 32'sd1;
  localparam int CNT_W   = 8;

  localparam logic [MANT_W-1:0] Q_MIN = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [MANT_W-1:0] Q_MAX = {MANT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RCP  = 3'd1,
    ST_MUL  = 3'd2,
    ST_RES  = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Scale {1,A}*{1,R} back to a 24-bit 1.q value; the rcp result carries an extra 2^-1
  // unless B==0, and A<B moves the quotient up one binade.
  function automatic logic [MANT_W-1:0] quot_est(input logic [PROD_W-1:0] p,
                                                 input logic e,
                                                 input logic s);
    logic [PROD_W-1:0] sh;
    case ({e, s})
      2'b10:        sh = p >> MANT_W;
      2'b11, 2'b00: sh = p >> FRAC_W;
      default:      sh = p >> FRAC_M1;
    endcase
    return sh[MANT_W-1:0];
  endfunction

endpackage

// File: rtl/flt_div_resid.sv
// Residual r = N - Q*D for the current estimate, plus range flags of the registered residual.
module flt_div_resid
  import flt_div_pkg::*;
(
  input  logic [RES_W-1:0]        n,
  input  logic [MANT_W-1:0]       q,
  input  logic [MANT_W-1:0]       d,
  output logic signed [RES_W-1:0] r,
  input  logic signed [RES_W-1:0] r_chk,
  output logic                    neg,
  output logic                    ge_d
);

  logic [RES_W-1:0] qd_s;
  logic [RES_W-1:0] d_ext_s;

  assign qd_s    = RES_W'(q) * RES_W'(d);
  assign d_ext_s = RES_W'(d);
  assign r       = $signed(n - qd_s);

  // Flags are taken from the residual latched in the previous cycle so the compare
  // does not sit behind the 24x24 multiply.
  assign neg  = r_chk[RES_W-1];
  assign ge_d = ~r_chk[RES_W-1] && ($unsigned(r_chk) >= d_ext_s);

endmodule

// File: rtl/flt_mant_div.sv
// Multi-cycle mantissa divider: reciprocal-based estimate refined by whole-ulp corrections
// until the quotient equals the exact truncated value of 1.A / 1.B.
module flt_mant_div
  import flt_div_pkg::*;
#(
  parameter int FLT_WIDTH = FRAC_W,
  parameter int RCP_LAT   = 0,
  parameter int MAX_CORR  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [FLT_WIDTH-1:0] i_A,
  input  logic [FLT_WIDTH-1:0] i_B,
  output logic [FLT_WIDTH-1:0] o_rcp_x,
  input  logic [FLT_WIDTH-1:0] i_rcp_r,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [FLT_WIDTH-1:0] o_q,
  output logic                 o_shift,
  output logic                 o_err
);

  state_e                  state_r;
  logic [FRAC_W-1:0]       a_r;
  logic [FRAC_W-1:0]       b_r;
  logic                    s_r;
  logic                    e_r;
  logic                    err_r;
  logic [MANT_W-1:0]       q_r;
  logic signed [RES_W-1:0] r_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        k_r;

  logic [PROD_W-1:0]       prod_s;
  logic [RES_W-1:0]        n_s;
  logic [MANT_W-1:0]       d_s;
  logic signed [RES_W-1:0] r_s;
  logic                    neg_s;
  logic                    ge_d_s;

  assign d_s    = {1'b1, b_r};
  assign prod_s = PROD_W'({1'b1, a_r}) * PROD_W'({1'b1, i_rcp_r});
  assign n_s    = s_r ? (RES_W'({1'b1, a_r}) << MANT_W) : (RES_W'({1'b1, a_r}) << FRAC_W);

  flt_div_resid u_resid (
    .n     (n_s),
    .q     (q_r),
    .d     (d_s),
    .r     (r_s),
    .r_chk (r_r),
    .neg   (neg_s),
    .ge_d  (ge_d_s)
  );

  // Control FSM, operand/estimate registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_q     <= '0;
      o_shift <= 1'b0;
      o_err   <= 1'b0;
      o_rcp_x <= '0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= 1'b0;
      e_r     <= 1'b0;
      err_r   <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
      cnt_r   <= '0;
      k_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            a_r     <= i_A;
            b_r     <= i_B;
            o_rcp_x <= i_B;
            s_r     <= (i_A < i_B);
            e_r     <= (i_B != '0);
            err_r   <= 1'b0;
            cnt_r   <= '0;
            k_r     <= '0;
            o_ready <= 1'b0;
            state_r <= (RCP_LAT == 0) ? ST_MUL : ST_RCP;
          end
        end
        ST_RCP: begin
          if (cnt_r == CNT_W'(RCP_LAT - 1)) begin
            state_r <= ST_MUL;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_MUL: begin
          q_r     <= quot_est(prod_s, e_r, s_r);
          state_r <= ST_RES;
        end
        ST_RES: begin
          r_r     <= r_s;
          state_r <= ST_CHK;
        end
        ST_CHK: begin
          if (!neg_s && !ge_d_s) begin
            state_r <= ST_DONE;
          end else if (k_r == CNT_W'(MAX_CORR)) begin
            err_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            // Step one ulp toward the exact quotient, pinned to the 1.q range.
            if (neg_s) begin
              if (q_r <= Q_MIN) begin
                q_r   <= Q_MIN;
                err_r <= 1'b1;
              end else begin
                q_r <= q_r - MANT_W'(1);
              end
            end else begin
              if (q_r == Q_MAX) begin
                err_r <= 1'b1;
              end else begin
                q_r <= q_r + MANT_W'(1);
              end
            end
            k_r     <= k_r + CNT_W'(1);
            state_r <= ST_RES;
          end
        end
        ST_DONE: begin
          if (!o_valid) begin
            o_valid <= 1'b1;
            o_q     <= q_r[FRAC_W-1:0];
            o_shift <= s_r;
            o_err   <= err_r;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flt_mant_div.sv
// Directed and filtered-random checks of flt_mant_div against a division-based golden quotient.
module tb_flt_mant_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [22:0] i_A;
  logic [22:0] i_B;
  logic [22:0] o_rcp_x;
  logic [22:0] i_rcp_r;
  logic        o_valid;
  logic        i_ready;
  logic [22:0] o_q;
  logic        o_shift;
  logic        o_err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] bias_v = 64'd0;
  logic [63:0] rcp_full;

  always #5 clk = ~clk;

  flt_mant_div dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_rcp_x (o_rcp_x),
    .i_rcp_r (i_rcp_r),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_q     (o_q),
    .o_shift (o_shift),
    .o_err   (o_err)
  );

  // Reciprocal unit model: truncated 2^47/{1,B} plus a configurable ulp bias.
  always_comb begin
    rcp_full = 64'd0;
    i_rcp_r  = 23'd0;
    if (o_rcp_x != 23'd0) begin
      rcp_full = (64'd1 << 47) / {40'd0, 1'b1, o_rcp_x} + bias_v;
      if (rcp_full > 64'hFF_FFFF) rcp_full = 64'hFF_FFFF;
      i_rcp_r = rcp_full[22:0];
    end
  end

  function automatic logic [63:0] gold_q(input logic [22:0] a, input logic [22:0] b);
    logic [63:0] ma;
    logic [63:0] mb;
    ma = {40'd0, 1'b1, a};
    mb = {40'd0, 1'b1, b};
    return (a < b) ? ((ma << 24) / mb) : ((ma << 23) / mb);
  endfunction

  function automatic logic [63:0] est_q(input logic [22:0] a, input logic [22:0] b,
                                        input logic [63:0] bias);
    logic [63:0] ma;
    logic [63:0] rf;
    ma = {40'd0, 1'b1, a};
    if (b == 23'd0) return ma;
    rf = (64'd1 << 47) / {40'd0, 1'b1, b} + bias;
    if (rf > 64'hFF_FFFF) rf = 64'hFF_FFFF;
    return (a < b) ? ((ma * rf) >> 23) : ((ma * rf) >> 24);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [22:0] a, input logic [22:0] b, output int lat);
    @(negedge clk);
    i_A     = a;
    i_B     = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    check("busy_after_accept", {63'd0, o_ready}, 64'd0);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_op();
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check("valid_drop", {63'd0, o_valid}, 64'd0);
    check("ready_back", {63'd0, o_ready}, 64'd1);
  endtask

  initial begin
    int          lat;
    logic [22:0] ra;
    logic [22:0] rb;
    logic [63:0] qe;
    logic [63:0] g;
    logic [63:0] kk;

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_A = 23'd0; i_B = 23'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_q", {41'd0, o_q}, 64'd0);
    check("rst_shift", {63'd0, o_shift}, 64'd0);
    check("rst_err", {63'd0, o_err}, 64'd0);
    check("rst_rcp_x", {41'd0, o_rcp_x}, 64'd0);
    rst = 1'b0;

    // T1: 1.0 / 1.0
    do_op(23'd0, 23'd0, lat);
    check("t1_lat", 64'(lat), 64'd4);
    check("t1_q", {41'd0, o_q}, 64'd0);
    check("t1_shift", {63'd0, o_shift}, 64'd0);
    check("t1_err", {63'd0, o_err}, 64'd0);
    release_op();

    // T2: 1.5 / 1.0
    do_op(23'h40_0000, 23'd0, lat);
    check("t2_lat", 64'(lat), 64'd4);
    check("t2_q", {41'd0, o_q}, 64'h40_0000);
    check("t2_shift", {63'd0, o_shift}, 64'd0);
    release_op();

    // T3: 1.0 / 1.5 with exact reciprocal
    do_op(23'd0, 23'h40_0000, lat);
    check("t3_q", {41'd0, o_q}, 64'h2A_AAAA);
    check("t3_shift", {63'd0, o_shift}, 64'd1);
    check("t3_err", {63'd0, o_err}, 64'd0);
    check("t3_rcp_x", {41'd0, o_rcp_x}, 64'h40_0000);
    release_op();

    // A == B gives exactly 1.0
    do_op(23'h12_3456, 23'h12_3456, lat);
    check("aeqb_q", {41'd0, o_q}, 64'd0);
    check("aeqb_shift", {63'd0, o_shift}, 64'd0);
    check("aeqb_err", {63'd0, o_err}, 64'd0);
    release_op();

    // T4: reciprocal biased +2 ulp; operands kept within the correction budget
    bias_v = 64'd2;
    for (int i = 0; i < 1000; i++) begin
      do begin
        ra = 23'($urandom);
        rb = 23'($urandom);
        qe = est_q(ra, rb, bias_v);
        g  = gold_q(ra, rb);
        kk = (qe > g) ? (qe - g) : (g - qe);
      end while (kk > 64'd3 || qe > 64'hFF_FFFF);
      do_op(ra, rb, lat);
      check("t4_lat", 64'(lat), 64'd4 + 64'd2 * kk);
      check("t4_q", {41'd0, o_q}, {41'd0, g[22:0]});
      check("t4_shift", {63'd0, o_shift}, {63'd0, (ra < rb)});
      check("t4_err", {63'd0, o_err}, 64'd0);
      release_op();
    end

    // T5: +10 ulp bias exhausts three corrections; estimate 0xAAAAB3 ends at 0xAAAAB0
    bias_v = 64'd10;
    do_op(23'h7F_FFFF, 23'h40_0000, lat);
    check("t5_lat", 64'(lat), 64'd10);
    check("t5_err", {63'd0, o_err}, 64'd1);
    check("t5_q", {41'd0, o_q}, 64'h2A_AAB0);
    check("t5_shift", {63'd0, o_shift}, 64'd0);
    for (int j = 0; j < 5; j++) begin
      i_valid = (j < 4);
      i_A     = 23'h00_0123;
      @(posedge clk);
      #1;
      check("t5_hold_valid", {63'd0, o_valid}, 64'd1);
      check("t5_hold_q", {41'd0, o_q}, 64'h2A_AAB0);
      check("t5_hold_err", {63'd0, o_err}, 64'd1);
      check("t5_hold_ready", {63'd0, o_ready}, 64'd0);
    end
    i_valid = 1'b0;
    release_op();

    // T6: reset while in CHK aborts the operation
    bias_v = 64'd0;
    @(negedge clk);
    i_A = 23'h40_0000; i_B = 23'h20_0000; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid", {63'd0, o_valid}, 64'd0);
    check("t6_ready", {63'd0, o_ready}, 64'd1);
    do_op(23'h40_0000, 23'd0, lat);
    check("t6_lat", 64'(lat), 64'd4);
    check("t6_q", {41'd0, o_q}, 64'h40_0000);
    check("t6_err", {63'd0, o_err}, 64'd0);
    release_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
